// File: rtl/lif_neuron_tile_if.sv
// Handshake and data bundle between the LIF tile and its memory/spike-buffer neighbours.
// The master side drives the timestep controls and memory data; the slave side is the tile.
interface lif_neuron_tile_if #(
    parameter int unsigned size_data     = 8,
    parameter int unsigned size_vmem     = 16,
    parameter int unsigned size_counters = 5,
    parameter int unsigned size_tile     = 4
);
    logic                            enable;
    logic                            memReady;
    logic                            finished;
    logic [size_tile*size_data-1:0]  weightData;
    logic [size_tile*size_vmem-1:0]  vmemData;
    logic [size_vmem-1:0]            threshold;
    logic [size_vmem-1:0]            leak;
    logic [size_tile-1:0]            spikeOut;
    logic [size_tile*size_vmem-1:0]  vmemOut;
    logic [size_counters-1:0]        eventCount;
    logic                            done;
    logic [1:0]                      stateOut;

    modport master (
        output enable, memReady, finished, weightData, vmemData, threshold, leak,
        input  spikeOut, vmemOut, eventCount, done, stateOut
    );

    modport slave (
        input  enable, memReady, finished, weightData, vmemData, threshold, leak,
        output spikeOut, vmemOut, eventCount, done, stateOut
    );
endinterface

// File: rtl/lif_neuron_tile.sv
// Leaky integrate-and-fire tile: loads size_tile membrane potentials, accumulates one
// weight row per presynaptic event, then leaks, thresholds, spikes and resets per lane.
module lif_neuron_tile #(
    parameter int unsigned size_data     = 8,
    parameter int unsigned size_vmem     = 16,
    parameter int unsigned size_counters = 5,
    parameter int unsigned size_tile     = 4,
    parameter int unsigned reset_mode    = 0
) (
    input  logic               clk,
    input  logic               reset,
    lif_neuron_tile_if.slave   bus
);

    // Two guard bits cover vmem +/- a zero-extended leak or a full-range threshold.
    localparam int unsigned ext_w = size_vmem + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        ACCUM = 2'b10,
        FIRE  = 2'b11
    } state_t;

    state_t                          state;
    logic signed [size_vmem-1:0]     vmem [size_tile];
    logic [size_tile-1:0]            spike_q;
    logic [size_tile*size_vmem-1:0]  vmem_out_q;
    logic [size_counters-1:0]        cnt_q;
    logic                            done_q;

    logic signed [size_vmem-1:0]     acc_v  [size_tile];
    logic signed [size_vmem-1:0]     leak_v [size_tile];
    logic signed [size_vmem-1:0]     fire_v [size_tile];
    logic [size_tile-1:0]            spike_c;

    // Clamp an extended-width result into the signed vmem range.
    function automatic logic signed [size_vmem-1:0] sat(input logic signed [ext_w-1:0] x);
        logic [ext_w-size_vmem:0] top;
        top = x[ext_w-1:size_vmem-1];
        if (top == '0 || top == '1)
            sat = x[size_vmem-1:0];
        else if (x[ext_w-1])
            sat = {1'b1, {(size_vmem-1){1'b0}}};
        else
            sat = {1'b0, {(size_vmem-1){1'b1}}};
    endfunction

    // Per-lane accumulate and fire datapath.
    always_comb begin
        acc_v   = '{default: '0};
        leak_v  = '{default: '0};
        fire_v  = '{default: '0};
        spike_c = '0;
        for (int i = 0; i < size_tile; i++) begin
            acc_v[i]  = sat(ext_w'(vmem[i])
                          + ext_w'($signed(bus.weightData[i*size_data +: size_data])));
            leak_v[i] = sat(ext_w'(vmem[i]) - $signed(ext_w'(bus.leak)));
            spike_c[i] = (leak_v[i] >= $signed(bus.threshold));
            if (!spike_c[i])
                fire_v[i] = leak_v[i];
            else if (reset_mode == 1)
                fire_v[i] = sat(ext_w'(leak_v[i]) - ext_w'($signed(bus.threshold)));
            else
                fire_v[i] = '0;
        end
    end

    // Timestep sequencer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vmem       <= '{default: '0};
            spike_q    <= '0;
            vmem_out_q <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state <= LOAD;
                        cnt_q <= '0;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < size_tile; i++)
                        vmem[i] <= bus.vmemData[i*size_vmem +: size_vmem];
                    state <= ACCUM;
                end
                ACCUM: begin
                    if (bus.memReady) begin
                        for (int i = 0; i < size_tile; i++)
                            vmem[i] <= acc_v[i];
                        if (cnt_q != '1)
                            cnt_q <= cnt_q + size_counters'(1);
                    end
                    if (bus.finished)
                        state <= FIRE;
                end
                FIRE: begin
                    for (int i = 0; i < size_tile; i++) begin
                        vmem[i]                               <= fire_v[i];
                        vmem_out_q[i*size_vmem +: size_vmem] <= fire_v[i];
                    end
                    spike_q <= spike_c;
                    done_q  <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.spikeOut   = spike_q;
    assign bus.vmemOut    = vmem_out_q;
    assign bus.eventCount = cnt_q;
    assign bus.done       = done_q;
    assign bus.stateOut   = state;

endmodule

// File: tb/tb_lif_neuron_tile.sv
// Scoreboard bench: two tiles (zero-reset and subtract-reset) driven with identical timesteps.
module tb_lif_neuron_tile;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   ts_id = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lif_neuron_tile_if #(.size_data(8), .size_vmem(16), .size_counters(5), .size_tile(4)) if0 ();
    lif_neuron_tile_if #(.size_data(8), .size_vmem(16), .size_counters(5), .size_tile(4)) if1 ();

    lif_neuron_tile #(.size_data(8), .size_vmem(16), .size_counters(5), .size_tile(4),
                      .reset_mode(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    lif_neuron_tile #(.size_data(8), .size_vmem(16), .size_counters(5), .size_tile(4),
                      .reset_mode(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    typedef struct {
        logic [3:0]  sp0;
        logic [63:0] vm0;
        logic [3:0]  sp1;
        logic [63:0] vm1;
        logic [4:0]  cnt;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic logic [31:0] pack_w(input int w[4]);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(w[i]);
        return r;
    endfunction

    function automatic logic [63:0] pack_v(input int v[4]);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(v[i]);
        return r;
    endfunction

    task automatic drive(input logic en, input logic mr, input logic fin, input logic [31:0] w);
        if0.enable = en;  if0.memReady = mr;  if0.finished = fin;  if0.weightData = w;
        if1.enable = en;  if1.memReady = mr;  if1.finished = fin;  if1.weightData = w;
    endtask

    task automatic set_mem(input logic [63:0] v, input int lk, input int thr);
        if0.vmemData = v;  if0.leak = 16'(lk);  if0.threshold = 16'(thr);
        if1.vmemData = v;  if1.leak = 16'(lk);  if1.threshold = 16'(thr);
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check_val({tag, " spike0"}, 64'(if0.spikeOut), 64'(e.sp0));
        check_val({tag, " vmem0"},  if0.vmemOut,       e.vm0);
        check_val({tag, " spike1"}, 64'(if1.spikeOut), 64'(e.sp1));
        check_val({tag, " vmem1"},  if1.vmemOut,       e.vm1);
        check_val({tag, " cnt0"},   64'(if0.eventCount), 64'(e.cnt));
        check_val({tag, " cnt1"},   64'(if1.eventCount), 64'(e.cnt));
    endtask

    // One full timestep: model -> queue, drive stimulus, pop on done and compare.
    task automatic run_ts(input int init[4], input int w[4], input int nev, input int lk,
                          input int thr, input bit sep_fin, input bit noise);
        exp_t  e;
        int    v[4], r0[4], r1[4];
        int    start;
        bit    got;
        string tag;
        ts_id++;
        tag = $sformatf("ts%0d", ts_id);
        for (int i = 0; i < 4; i++) begin
            v[i] = init[i];
            for (int k = 0; k < nev; k++) v[i] = clamp(v[i] + w[i]);
            v[i] = clamp(v[i] - lk);
            e.sp0[i] = (v[i] >= thr);
            e.sp1[i] = e.sp0[i];
            r0[i] = e.sp0[i] ? 0 : v[i];
            r1[i] = e.sp0[i] ? clamp(v[i] - thr) : v[i];
        end
        e.vm0 = pack_v(r0);
        e.vm1 = pack_v(r1);
        e.cnt = (nev > 31) ? 5'd31 : 5'(nev);
        e.lat = 3 + nev + (sep_fin ? 1 : 0);
        exp_q.push_back(e);

        @(negedge clk);
        set_mem(pack_v(init), lk, thr);
        drive(1'b1, 1'b0, 1'b0, '0);
        start = cyc;
        @(negedge clk);
        drive(1'b0, noise, 1'b0, 32'h6363_6363);
        @(negedge clk);
        for (int k = 0; k < nev; k++) begin
            drive(noise, 1'b1, (!sep_fin && k == nev - 1), pack_w(w));
            @(negedge clk);
        end
        if (sep_fin) begin
            drive(1'b0, 1'b0, 1'b1, pack_w(w));
            @(negedge clk);
        end
        drive(1'b0, noise, 1'b0, 32'h7F7F_7F7F);

        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(posedge clk);
            #1;
            if (if0.done) got = 1'b1;
        end
        if (exp_q.size() == 0) begin
            check_val({tag, " queue_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, " done_seen"}, 64'(got), 64'd1);
            check_val({tag, " done1"}, 64'(if1.done), 64'(got));
            check_val({tag, " latency"}, 64'(cyc - start), 64'(e.lat));
            check_outputs(tag, e);
            last_e = e;
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        check_val({tag, " done_pulse"}, 64'(if0.done), 64'd0);
        check_val({tag, " idle"}, 64'(if0.stateOut), 64'd0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0);
        set_mem('0, 0, 0);
        repeat (3) @(negedge clk);
        check_val("rst state", 64'(if0.stateOut), 64'd0);
        check_val("rst spike", 64'(if0.spikeOut), 64'd0);
        check_val("rst vmem",  if1.vmemOut, 64'd0);
        check_val("rst cnt",   64'(if0.eventCount), 64'd0);
        check_val("rst done",  64'(if1.done), 64'd0);
        reset = 1'b0;

        run_ts('{10, 10, 10, 10}, '{5, 5, 5, 5}, 2, 2, 15, 1'b1, 1'b0);
        run_ts('{10, 10, 10, 10}, '{5, -5, 0, 8}, 1, 0, 12, 1'b0, 1'b0);
        run_ts('{32760, 32760, 32760, 32760}, '{127, 127, 127, 127}, 1, 0, -1, 1'b0, 1'b0);
        run_ts('{-32760, -32760, -32760, -32760}, '{-128, -128, -128, -128}, 1, 100, 0,
               1'b0, 1'b0);
        run_ts('{0, 0, 0, 0}, '{1, 1, 1, 1}, 40, 0, 100, 1'b1, 1'b0);
        run_ts('{100, -50, 0, 7}, '{-3, 4, 1, -7}, 3, 1, 5, 1'b1, 1'b1);

        // memReady pulses in IDLE must leave outputs and state untouched
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h1111_1111);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0);
        check_outputs("idle_hold", last_e);
        check_val("idle_hold state", 64'(if0.stateOut), 64'd0);

        // reset asserted after two accumulated events
        @(negedge clk);
        set_mem(pack_v('{1000, 1000, 1000, 1000}), 0, 0);
        drive(1'b1, 1'b0, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0505_0505);
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0);
        check_val("pre_rst cnt", 64'(if0.eventCount), 64'd2);
        check_val("pre_rst state", 64'(if0.stateOut), 64'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst state", 64'(if0.stateOut), 64'd0);
        check_val("mid_rst spike", 64'(if0.spikeOut), 64'd0);
        check_val("mid_rst vmem0", if0.vmemOut, 64'd0);
        check_val("mid_rst vmem1", if1.vmemOut, 64'd0);
        check_val("mid_rst cnt",   64'(if1.eventCount), 64'd0);
        check_val("mid_rst done",  64'(if0.done), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_ts('{10, 10, 10, 10}, '{5, 5, 5, 5}, 2, 2, 15, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lif_neuron_tile.md
Name: lif_neuron_tile

Overview:
Parametrised leaky integrate-and-fire tile that updates size_tile neurons in parallel for one timestep. It loads membrane potentials from vmem memory and accumulates one weight row per presynaptic event. At timestep end it applies leak, threshold compare, spike generation and a selectable reset mode, then writes back updated potentials. It sits between the weight/vmem memory interface and the layer spike buffer in the snn_top datapath.

Parameters:
size_data, 8, signed weight width per neuron
size_vmem, 16, signed membrane potential width per neuron
size_counters, 5, width of the per-timestep event counter
size_tile, 4, neurons per tile (lanes)
reset_mode, 0, 0 = reset-to-zero on spike, 1 = subtract threshold on spike

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  start-of-timestep request, sampled in IDLE only
memReady  in  1  weightData valid for one presynaptic event, sampled in ACCUM only
finished  in  1  last event delivered; ends accumulation, sampled in ACCUM only
weightData  in  size_tile*size_data  signed weights; lane i = bits [i*size_data +: size_data]
vmemData  in  size_tile*size_vmem  stored potentials, captured in LOAD
threshold  in  size_vmem  signed firing threshold, common to all lanes, sampled in FIRE
leak  in  size_vmem  unsigned leak per timestep, sampled in FIRE
spikeOut  out  size_tile  registered spike vector, bit i = lane i
vmemOut  out  size_tile*size_vmem  updated potentials for write-back
eventCount  out  size_counters  events accumulated this timestep
done  out  1  one-cycle pulse: spikeOut/vmemOut valid
stateOut  out  2  FSM state (debug)

Behaviour:
- Reset (any time, including mid-timestep): state = IDLE (2'b00); spikeOut, vmemOut, eventCount, done and internal vmem registers all clear to 0.
- FSM encoding: IDLE = 00, LOAD = 01, ACCUM = 10, FIRE = 11.
- IDLE: when enable = 1, go to LOAD and clear eventCount. Other inputs are ignored.
- LOAD (1 cycle): internal vmem[i] <= vmemData lane i; go to ACCUM unconditionally.
- ACCUM:
  - Each cycle with memReady = 1: vmem[i] <= sat(vmem[i] + sext(w[i])).
  - Saturation is to the signed range [-2^(size_vmem-1), 2^(size_vmem-1)-1].
  - eventCount increments on each such cycle and saturates at all-ones (no wrap).
- ACCUM exit: when finished = 1, go to FIRE. If memReady is also 1 in that cycle, that event is accumulated first.
- FIRE (1 cycle), per lane:
  - v = sat(vmem[i] - leak), with leak zero-extended before subtraction.
  - spike = (v >= threshold), signed compare.
  - If spike and reset_mode = 0: result = 0. If spike and reset_mode = 1: result = sat(v - threshold). No spike: result = v.
  - Register the result into vmem[i] and vmemOut lane i; spikeOut[i] <= spike; done <= 1 in the following cycle; next state = IDLE.
- done is high for exactly one cycle, the first cycle back in IDLE.
- spikeOut, vmemOut and eventCount hold their values until the next FIRE, or until reset.
- Latency: enable to done = 3 + N cycles for N ACCUM cycles (minimum N = 1).
- enable in non-IDLE states, and memReady/finished outside ACCUM, have no effect.

Test Plan:
- Reset mid-ACCUM: assert reset after 2 events -> next edge has stateOut = 00 and all outputs 0; a following enable runs a clean timestep.
- Basic fire, reset_mode = 0: vmemData lanes = 10, weights {+5,+5} over 2 events, leak = 2, threshold = 15 -> v = 18, spikeOut = 1111, vmemOut lanes = 0, eventCount = 2, done pulses 1 cycle.
- Subtract mode, reset_mode = 1: same stimulus -> vmemOut lanes = 3, spikeOut = 1111. Mixed lanes with weights {+5,-5,0,+8} x1, vmem 10, leak 0, threshold 12 -> spikeOut = 1001, vmemOut = {6, 5, 10, 3}, with lane 0 the rightmost value and bit 0 the rightmost bit.
- Saturation: vmem = 32760, weight +127 -> 32767 with no wrap; vmem = -32760, weight -128, leak 100 -> -32768. Run 40 events with size_counters = 5 -> eventCount = 31.
- Simultaneous memReady and finished on the first ACCUM cycle: weight is accumulated, eventCount = 1, done arrives 4 cycles after enable.
- Ignored inputs: memReady pulses in IDLE/LOAD/FIRE and enable during ACCUM -> no change to vmem or eventCount, and no extra timestep.
